fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
Parametrised single-clock synchronous FIFO. Successor to the team's fixed 8-bit x 16 FIFO, generalised in width and depth. Adds the following:
- almost-full and almost-empty flags with programmable thresholds
- an occupancy count output
- a read-data-valid strobe
- sticky overflow and underflow error flags
- a correct count when read and write happen in the same cycle

It buffers data between producer and consumer blocks in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1)
Derived constants: AW = $clog2(DEPTH); CW = AW+1.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
write_en  in  1  write request
data_in  in  DATA_W  write data
read_en  in  1  read request
data_out  out  DATA_W  registered read data
rd_valid  out  1  one-cycle pulse; data_out holds the word for an accepted read
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  CW  current occupancy, 0..DEPTH
overflow  out  1  sticky; a write was attempted while full
underflow  out  1  sticky; a read was attempted while empty

Behaviour:
- Reset: one clock, single domain. Reset is synchronous and active-low; it is sampled only on a clk rising edge with reset==0.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, data_out=0, rd_valid=0, overflow=0, underflow=0. Memory contents are not reset.
- After reset: empty=1, full=0, almost_empty=1, and almost_full=(AFULL_TH==0 ? 1 : 0). AFULL_TH>=1 is enforced by an elaboration-time assertion.
- Accept rules: wr_acc = write_en & ~full; rd_acc = read_en & ~empty. Both are evaluated on the pre-edge flag values.
- Write: on wr_acc, mem[wr_ptr] <= data_in and wr_ptr <= wr_ptr+1. The pointer wraps modulo DEPTH naturally (AW bits).
- Read: on rd_acc, data_out <= mem[rd_ptr], rd_ptr <= rd_ptr+1, and rd_valid <= 1 on the next edge. The data is visible one cycle after read_en is sampled.
- When no read is accepted: rd_valid <= 0 and data_out holds its value.
- Count update:
  - wr_acc & ~rd_acc: +1
  - rd_acc & ~wr_acc: -1
  - both accepted: unchanged
- Simultaneous request while full: the read is accepted, the write is rejected, overflow is set, and count becomes DEPTH-1.
- Simultaneous request while empty: the write is accepted, the read is rejected, underflow is set, and count becomes 1. There is no fall-through; the written word is readable from the next cycle.
- Simultaneous read and write at partial fill: both are accepted and count is unchanged. The write never corrupts the word being read, because the pointers differ whenever count is between 1 and DEPTH-1.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of registered count only. No input-to-output combinational path exists.
- Sticky errors: overflow is set on write_en & full, and underflow is set on read_en & empty. Both stay set until reset.
- Reset mid-operation: reset has priority over all requests in that cycle. Stored data is discarded logically and the FIFO reads as empty on the next cycle.
- Count is kept separately from the pointers and must always satisfy count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when the pointers are equal and the FIFO is full.

Decomposition:
- Shared package fifo_pkg:
  - function fifo_aw(depth) returning $clog2
  - typedef fifo_err_t, a struct {overflow, underflow} for status aggregation by upstream blocks
  - localparam default DATA_W and DEPTH values
- Sub-module fifo_sdp_ram: a simple dual-port memory with one write port and one registered read port, parametrised DATA_W/DEPTH, with no reset on the array. It maps cleanly to inferred block RAM.
- Pointer, count, flag and error logic stays in fifo_sync_param.

Test Plan (DATA_W=8, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2):
- Reset then idle -> empty=1, almost_empty=1, full=0, count=0, data_out=0x00, rd_valid=0, overflow=0, underflow=0.
- Write 0x01..0x10 (16 words), then read 16 -> almost_full rises at count=14, full at 16. Reads return 0x01..0x10 in order, each one cycle after read_en with rd_valid=1. Finishes with empty=1.
- Full, then write 0xAA with read_en=0 -> count stays 16 and overflow=1. Later reads never return 0xAA, and overflow stays 1 until reset.
- Empty, then read_en=1 with write_en=1 and data_in=0x5C -> rd_valid=0, underflow=1, count=1. The next read returns 0x5C.
- Fill to 8, then 20 cycles of simultaneous write/read with an incrementing pattern -> count stays 8 throughout. Output order is preserved across pointer wrap past index 15.
- Fill to 10, then assert reset=0 for one cycle with write_en=1 -> next cycle count=0, empty=1, and sticky flags cleared. A following write/read of 0x3E returns 0x3E.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types, defaults and helpers for the synchronous FIFO
//               family.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_DEPTH_DEF  = 16;

    // Error status bundle so upstream blocks can aggregate FIFO health.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Address width needed to index DEPTH entries.
    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sdp_ram
// Description : Simple dual-port RAM, one write port and one registered read
//               port. The array itself is not reset; only the read register
//               clears, so the structure maps onto inferred block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [fifo_aw(DEPTH)-1:0]  waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       re,
    input  logic [fifo_aw(DEPTH)-1:0]  raddr,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port: storage array, deliberately without reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port: output register loads only on a read, otherwise holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param
// Description : Parametrised single-clock FIFO with occupancy count,
//               programmable almost-full/almost-empty flags, read-valid
//               strobe and sticky overflow/underflow flags.
// Revision    : 1.0 - generalised from the fixed 8x16 FIFO
// ============================================================================
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        write_en,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        read_en,
    output logic [DATA_W-1:0]           data_out,
    output logic                        rd_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [fifo_aw(DEPTH):0]     count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW = fifo_aw(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] c_depth     = CW'(DEPTH);
    localparam logic [CW-1:0] c_afull_th  = CW'(AFULL_TH);
    localparam logic [CW-1:0] c_aempty_th = CW'(AEMPTY_TH);

    // Reject illegal threshold/depth settings at elaboration.
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull_th
        $error("fifo_sync_param: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty_th
        $error("fifo_sync_param: AEMPTY_TH must be in 0..DEPTH-1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 2");
    end

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_rd_valid;
    fifo_err_t     r_err;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;

    // Flags decode registered count only, so no input reaches an output
    // combinationally.
    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = write_en & ~w_full;
    assign w_rd_acc = read_en & ~w_empty;

    // Pointers, occupancy, read strobe and sticky errors; reset wins over
    // any request in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_rd_valid <= w_rd_acc;
            if (write_en && w_full) begin
                r_err.overflow <= 1'b1;
            end
            if (read_en && w_empty) begin
                r_err.underflow <= 1'b1;
            end
        end
    end

    // Memory write is gated by reset so a request during reset leaves no
    // trace, even in the array.
    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (w_wr_acc & reset),
        .waddr (r_wr_ptr),
        .wdata (data_in),
        .re    (w_rd_acc & reset),
        .raddr (r_rd_ptr),
        .rdata (data_out)
    );

    assign rd_valid     = r_rd_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_afull_th);
    assign almost_empty = (r_count <= c_aempty_th);
    assign count        = r_count;
    assign overflow     = r_err.overflow;
    assign underflow    = r_err.underflow;

endmodule
`default_nettype wire
